// File: rtl/rtl_tp_ram_pkg.sv
// Shared types and constants for the two-port RAM with a self-clearing sequencer.
package rtl_tp_ram_pkg;

  // Clear sequencer states
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // Read-during-write selection
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage

// File: rtl/rtl_tp_ram_clr_seq.sv
// Clear sequencer: walks addresses 0..DEPTH-1 once per clear request and
// holds busy for exactly DEPTH cycles. Reset lands in CLEAR, so the memory
// initialises itself after every reset.
module rtl_tp_ram_clr_seq
  import rtl_tp_ram_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DEPTH = 1 << AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr_req,
  output logic          o_busy,
  output logic          o_clr_we,
  output logic [AW-1:0] o_clr_adr
);

  // One extra bit keeps DEPTH == 2^AW from wrapping before the end test.
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

  clr_state_e    r_state;
  logic [AW:0]   r_cnt;
  logic          r_busy;

  // FSM, address counter and registered busy; clr_req is only heard in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_clr_req) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (r_cnt == LAST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // No fill write on reset edges: the first post-reset edge writes address 0.
  assign o_clr_we  = (r_state == CLEAR) && !rst;
  assign o_clr_adr = r_cnt[AW-1:0];
  assign o_busy    = r_busy;

endmodule

// File: rtl/rtl_tp_ram_clr.sv
// Two-port RAM (one write, one read port) with byte enables, selectable
// read-during-write behaviour, 1- or 2-cycle read latency and a whole-array
// clear that runs one word per cycle.
module rtl_tp_ram_clr
  import rtl_tp_ram_pkg::*;
#(
  parameter int          AW       = 8,
  parameter int          DW       = 32,
  parameter int          DEPTH    = 1 << AW,
  parameter logic [DW-1:0] INITV  = '0,
  parameter int          RD_LAT   = 1,
  parameter int          RDW_MODE = RDW_OLD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_req,
  output logic            busy,
  input  logic            we,
  input  logic [AW-1:0]   wadr,
  input  logic [DW-1:0]   wdat,
  input  logic [DW/8-1:0] wbe,
  input  logic            re,
  input  logic [AW-1:0]   radr,
  output logic [DW-1:0]   rdat,
  output logic            rvld
);

  localparam int          NB      = DW / 8;
  localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];

  logic               w_busy;
  logic               w_clr_we;
  logic [AW-1:0]      w_clr_adr;
  logic               w_wr_ok;
  logic               w_rd_inr;
  logic               w_rd_acc;
  logic [IW-1:0]      w_widx;
  logic [IW-1:0]      w_ridx;
  logic [DW-1:0]      w_rd_word;

  logic [RD_LAT:1]          r_vld_pipe;
  logic [RD_LAT:1][DW-1:0]  r_dat_pipe;

  rtl_tp_ram_clr_seq #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .i_clr_req (clr_req),
    .o_busy    (w_busy),
    .o_clr_we  (w_clr_we),
    .o_clr_adr (w_clr_adr)
  );

  assign busy = w_busy;

  // User traffic is locked out while clearing; out-of-range writes vanish.
  assign w_wr_ok  = we && !w_busy && !rst && ({1'b0, wadr} < DEPTH_W);
  assign w_rd_inr = ({1'b0, radr} < DEPTH_W);
  assign w_rd_acc = re && !w_busy && !rst;
  assign w_widx   = wadr[IW-1:0];
  assign w_ridx   = radr[IW-1:0];

  // Storage write: clear fill has priority, user writes honour byte enables
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_adr[IW-1:0]] <= INITV;
    end else if (w_wr_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (wbe[b]) r_mem[w_widx][8*b +: 8] <= wdat[8*b +: 8];
      end
    end
  end

  // Read word: INITV out of range, otherwise stored word, optionally with
  // the same-edge write bytes folded in
  always_comb begin
    w_rd_word = INITV;
    if (w_rd_inr) begin
      w_rd_word = r_mem[w_ridx];
      if (RDW_MODE == RDW_NEW && w_wr_ok && (wadr == radr)) begin
        for (int b = 0; b < NB; b++) begin
          if (wbe[b]) w_rd_word[8*b +: 8] = wdat[8*b +: 8];
        end
      end
    end
  end

  // Read pipeline: valid shift register, data stages load only behind a
  // valid so the output word holds between results
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_dat_pipe <= '0;
    end else begin
      r_vld_pipe[1] <= w_rd_acc;
      if (w_rd_acc) r_dat_pipe[1] <= w_rd_word;
      for (int k = 2; k <= RD_LAT; k++) begin
        r_vld_pipe[k] <= r_vld_pipe[k-1];
        if (r_vld_pipe[k-1]) r_dat_pipe[k] <= r_dat_pipe[k-1];
      end
    end
  end

  assign rvld = r_vld_pipe[RD_LAT];
  assign rdat = r_dat_pipe[RD_LAT];

endmodule

// File: tb/tb_rtl_tp_ram_clr.sv
// Directed bench for rtl_tp_ram_clr: four instances share the data buses,
// each configured for a different corner (latency, RDW mode, depth, fill value).
module tb_rtl_tp_ram_clr;

  localparam logic [31:0] INIT_C = 32'hCAFE_F00D;
  localparam logic [31:0] INIT_D = 32'h5A5A_0FF0;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst_c, clr_c, clr_z;
  logic        we, re;
  logic [7:0]  wadr, radr;
  logic [31:0] wdat;
  logic [3:0]  wbe;

  logic        busy_a, busy_b, busy_c, busy_d;
  logic        rvld_a, rvld_b, rvld_c, rvld_d;
  logic [31:0] rdat_a, rdat_b, rdat_c, rdat_d;

  // A: 256 deep, latency 1, old-data RDW
  rtl_tp_ram_clr #(.AW(8), .DW(32), .DEPTH(256), .INITV(32'h0), .RD_LAT(1), .RDW_MODE(0)) u_a (
    .clk(clk), .rst(rst), .clr_req(clr_z), .busy(busy_a), .we(we), .wadr(wadr), .wdat(wdat),
    .wbe(wbe), .re(re), .radr(radr), .rdat(rdat_a), .rvld(rvld_a));
  // B: 256 deep, latency 2, new-data RDW
  rtl_tp_ram_clr #(.AW(8), .DW(32), .DEPTH(256), .INITV(32'h0), .RD_LAT(2), .RDW_MODE(1)) u_b (
    .clk(clk), .rst(rst), .clr_req(clr_z), .busy(busy_b), .we(we), .wadr(wadr), .wdat(wdat),
    .wbe(wbe), .re(re), .radr(radr), .rdat(rdat_b), .rvld(rvld_b));
  // C: 16 deep, latency 1, own reset and clear request
  rtl_tp_ram_clr #(.AW(8), .DW(32), .DEPTH(16), .INITV(INIT_C), .RD_LAT(1), .RDW_MODE(0)) u_c (
    .clk(clk), .rst(rst_c), .clr_req(clr_c), .busy(busy_c), .we(we), .wadr(wadr), .wdat(wdat),
    .wbe(wbe), .re(re), .radr(radr), .rdat(rdat_c), .rvld(rvld_c));
  // D: 200 deep, latency 2
  rtl_tp_ram_clr #(.AW(8), .DW(32), .DEPTH(200), .INITV(INIT_D), .RD_LAT(2), .RDW_MODE(0)) u_d (
    .clk(clk), .rst(rst), .clr_req(clr_z), .busy(busy_d), .we(we), .wadr(wadr), .wdat(wdat),
    .wbe(wbe), .re(re), .radr(radr), .rdat(rdat_d), .rvld(rvld_d));

  int n_vec = 0;
  int n_err = 0;

  task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0; clr_c = 1'b0;
    wadr = '0; radr = '0; wdat = '0; wbe = '0;
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  wadr;
    logic [31:0] wdat;
    logic [3:0]  wbe;
    logic        re;
    logic [7:0]  radr;
    logic        va;
    logic [31:0] da;
    logic        vb;
    logic [31:0] db;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int fa, fb, fc, fd, f2, f3;

    // we wadr wdat wbe re radr | A vld/dat | B vld/dat (B lags one row)
    tbl[0]  = '{1'b0, 8'h00, 32'h0000_0000, 4'h0, 1'b1, 8'h80, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000};
    tbl[1]  = '{1'b1, 8'h05, 32'hAABB_CCDD, 4'hF, 1'b0, 8'h00, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000};
    tbl[2]  = '{1'b1, 8'h05, 32'h1122_3344, 4'h5, 1'b0, 8'h00, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000};
    tbl[3]  = '{1'b0, 8'h00, 32'h0000_0000, 4'h0, 1'b1, 8'h05, 1'b1, 32'hAA22_CC44, 1'b0, 32'h0000_0000};
    tbl[4]  = '{1'b0, 8'h00, 32'h0000_0000, 4'h0, 1'b0, 8'h00, 1'b0, 32'hAA22_CC44, 1'b1, 32'hAA22_CC44};
    tbl[5]  = '{1'b1, 8'h09, 32'h1234_5678, 4'hF, 1'b1, 8'h09, 1'b1, 32'h0000_0000, 1'b0, 32'hAA22_CC44};
    tbl[6]  = '{1'b0, 8'h00, 32'h0000_0000, 4'h0, 1'b1, 8'h09, 1'b1, 32'h1234_5678, 1'b1, 32'h1234_5678};
    tbl[7]  = '{1'b1, 8'h09, 32'hFFFF_0000, 4'h3, 1'b1, 8'h09, 1'b1, 32'h1234_5678, 1'b1, 32'h1234_5678};
    tbl[8]  = '{1'b0, 8'h00, 32'h0000_0000, 4'h0, 1'b0, 8'h00, 1'b0, 32'h1234_5678, 1'b1, 32'h1234_0000};
    tbl[9]  = '{1'b0, 8'h00, 32'h0000_0000, 4'h0, 1'b1, 8'h09, 1'b1, 32'h1234_0000, 1'b0, 32'h1234_0000};
    tbl[10] = '{1'b1, 8'hFF, 32'h0102_0304, 4'hF, 1'b1, 8'hFF, 1'b1, 32'h0000_0000, 1'b1, 32'h1234_0000};
    tbl[11] = '{1'b0, 8'h00, 32'h0000_0000, 4'h0, 1'b1, 8'hFF, 1'b1, 32'h0102_0304, 1'b1, 32'h0102_0304};
    tbl[12] = '{1'b0, 8'h00, 32'h0000_0000, 4'h0, 1'b0, 8'h00, 1'b0, 32'h0102_0304, 1'b1, 32'h0102_0304};

    // Reset state, with a read attempted during reset
    rst = 1'b1; rst_c = 1'b1; clr_z = 1'b0;
    idle();
    re = 1'b1;
    repeat (3) step();
    chkb("rst_busy_a", busy_a, 1'b1);
    chkb("rst_busy_c", busy_c, 1'b1);
    chkb("rst_rvld_a", rvld_a, 1'b0);
    chkb("rst_rvld_b", rvld_b, 1'b0);
    chkw("rst_rdat_a", rdat_a, 32'h0);
    chkw("rst_rdat_d", rdat_d, 32'h0);
    idle();

    // Self-clear after reset release: busy lasts DEPTH cycles
    rst = 1'b0; rst_c = 1'b0;
    fa = 0; fb = 0; fc = 0; fd = 0;
    for (int k = 1; k <= 300; k++) begin
      step();
      if (!busy_a && fa == 0) fa = k;
      if (!busy_b && fb == 0) fb = k;
      if (!busy_c && fc == 0) fc = k;
      if (!busy_d && fd == 0) fd = k;
      if (fa != 0 && fb != 0 && fc != 0 && fd != 0) break;
    end
    chki("post_rst_busy_a", fa, 256);
    chki("post_rst_busy_b", fb, 256);
    chki("post_rst_busy_c", fc, 16);
    chki("post_rst_busy_d", fd, 200);

    // Table: byte enables, latency, read-during-write, hold, out-of-range
    for (int i = 0; i < 13; i++) begin
      we = tbl[i].we; wadr = tbl[i].wadr; wdat = tbl[i].wdat; wbe = tbl[i].wbe;
      re = tbl[i].re; radr = tbl[i].radr;
      step();
      chkb($sformatf("tbl%0d_rvld_a", i), rvld_a, tbl[i].va);
      chkw($sformatf("tbl%0d_rdat_a", i), rdat_a, tbl[i].da);
      chkb($sformatf("tbl%0d_rvld_b", i), rvld_b, tbl[i].vb);
      chkw($sformatf("tbl%0d_rdat_b", i), rdat_b, tbl[i].db);
    end
    idle();
    step();

    // Clear on C: fill a pattern first
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; wadr = 8'(i); wdat = 32'h100 + 32'(i); wbe = 4'hF;
      step();
    end
    idle();
    // Read accepted on the clr_req edge completes with pre-clear data
    re = 1'b1; radr = 8'd3; clr_c = 1'b1;
    step();
    idle();
    chkb("clr_inflight_rvld", rvld_c, 1'b1);
    chkw("clr_inflight_rdat", rdat_c, 32'h103);
    chkb("clr_busy_rise", busy_c, 1'b1);
    f2 = 0;
    for (int k = 1; k <= 40; k++) begin
      we = (k == 3); wadr = 8'd0; wdat = 32'h0000_0BAD; wbe = 4'hF;
      re = (k == 5); radr = 8'd6;
      clr_c = (k == 8);
      step();
      if (k == 5) chkb("clr_busy_read_blocked", rvld_c, 1'b0);
      if (!busy_c) begin
        f2 = k;
        break;
      end
    end
    idle();
    chki("clr_busy_len", f2, 16);
    for (int i = 0; i < 16; i++) begin
      re = 1'b1; radr = 8'(i);
      step();
      chkb($sformatf("clr_rb%0d_rvld", i), rvld_c, 1'b1);
      chkw($sformatf("clr_rb%0d_rdat", i), rdat_c, INIT_C);
    end
    idle();
    step();

    // Reset at clear address 7 restarts the clear from 0
    clr_c = 1'b1;
    step();
    clr_c = 1'b0;
    repeat (7) step();
    rst_c = 1'b1;
    repeat (2) step();
    chkb("midclr_rst_busy", busy_c, 1'b1);
    chkw("midclr_rst_rdat", rdat_c, 32'h0);
    rst_c = 1'b0;
    f3 = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (!busy_c) begin
        f3 = k;
        break;
      end
    end
    chki("midclr_restart_len", f3, 16);

    // Streaming reads on D (latency 2)
    for (int i = 0; i < 20; i++) begin
      we = 1'b1; wadr = 8'(i); wdat = 32'h3000 + 32'(i); wbe = 4'hF;
      step();
    end
    idle();
    for (int k = 0; k <= 21; k++) begin
      re = (k < 20); radr = 8'(k);
      step();
      if (k >= 1 && k <= 20) begin
        chkb($sformatf("strm%0d_rvld", k - 1), rvld_d, 1'b1);
        chkw($sformatf("strm%0d_rdat", k - 1), rdat_d, 32'h3000 + 32'(k - 1));
      end else begin
        chkb($sformatf("strm_edge%0d_rvld", k), rvld_d, 1'b0);
      end
    end
    // radr == DEPTH returns the fill value
    re = 1'b1; radr = 8'd200;
    step();
    idle();
    chkb("oor_first_rvld", rvld_d, 1'b0);
    chkw("oor_hold_rdat", rdat_d, 32'h3013);
    step();
    chkb("oor_rvld", rvld_d, 1'b1);
    chkw("oor_rdat", rdat_d, INIT_D);
    step();

    // Reset drops an in-flight read
    re = 1'b1; radr = 8'd3;
    step();
    idle();
    rst = 1'b1;
    step();
    chkb("rst_drop_rvld", rvld_d, 1'b0);
    chkw("rst_drop_rdat", rdat_d, 32'h0);
    rst = 1'b0;
    step();
    chkb("rst_drop_rvld2", rvld_d, 1'b0);
    chkb("rst_drop_busy", busy_d, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
